instr_prefetch: RTL and testbench

- Instruction fetch front-end between the multicycle RV32I core's instruction port and instruction memory.
- Issues sequential 32-bit fetches ahead of the core and buffers them with their PCs in a small in-order queue.
- Hands instructions to the core over a valid/ready handshake.
- Discards stale fetches when the core redirects after a taken branch, JAL or JALR.

---
 rtl/ipf_pkg.sv | 26 ++
 rtl/ipf_fifo.sv | 64 ++++++
 rtl/instr_prefetch.sv | 122 ++++++++++++
 tb/tb_instr_prefetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ipf_pkg                                                              |
// | Shared types and constants for the instruction prefetch front-end.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ipf_pkg;

  localparam int IPF_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [3:0] BYTE_EN_WORD = 4'b1111;

  // Queue entry: fetched word together with the PC it came from.
  // Field width fixes the instr_prefetch IW parameter to IPF_XLEN.
  typedef struct packed {
    logic [IPF_XLEN-1:0] instr;
    logic [IPF_XLEN-1:0] pc;
  } ipf_entry_t;

  // Counters must represent 0..depth inclusive.
  function automatic int ipf_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ipf_fifo                                                             |
// | Synchronous in-order FIFO of ipf_entry_t; flush beats push and pop.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ipf_fifo
  import ipf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = ipf_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  ipf_entry_t    i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output ipf_entry_t    o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  ipf_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch                                                       |
// | Sequential instruction prefetcher with redirect flush. Optional      |
// | same-cycle response bypass when IPF_BYPASS_EN is defined.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_prefetch
  import ipf_pkg::*;
#(
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [IW-1:0] RESET_PC = {IW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_redirect,
  input  logic [IW-1:0] i_redirect_pc,
  output logic [IW-1:0] o_instr,
  output logic [IW-1:0] o_instr_pc,
  output logic          o_instr_valid,
  input  logic          i_instr_ready,
  output logic [IW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic [3:0]    o_mem_byte_en,
  input  logic          i_mem_waitrequest,
  input  logic [IW-1:0] i_mem_rddata,
  input  logic          i_mem_rdvalid
);

  localparam int            CW      = ipf_cnt_w(DEPTH);
  localparam logic [CW:0]   c_depth = (CW+1)'(DEPTH);
  localparam logic [IW-1:0] c_step  = IW'(INSTR_BYTES);
  localparam logic [IW-1:0] c_align = ~IW'(INSTR_BYTES - 1);

  logic [IW-1:0] r_fetch_pc;
  logic [IW-1:0] r_fill_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_level;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_rsp;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_redirect_pc;
  ipf_entry_t    w_push_data;
  ipf_entry_t    w_head;

  // A response with nothing outstanding belongs to a fetch killed by reset.
  assign w_rsp  = i_mem_rdvalid && (r_outstanding != '0);
  assign w_keep = w_rsp && (r_drop == '0) && !i_redirect;

  assign w_level       = {1'b0, w_count} + {1'b0, r_outstanding};
  assign o_mem_rd      = !reset && !i_redirect && (w_level < c_depth);
  assign o_mem_addr    = r_fetch_pc;
  assign o_mem_byte_en = BYTE_EN_WORD;
  assign w_accept      = o_mem_rd && !i_mem_waitrequest;

  assign w_redirect_pc = i_redirect_pc & c_align;
  assign w_push_data   = '{instr: i_mem_rddata, pc: r_fill_pc};
  assign w_pop         = !w_empty && i_instr_ready && !i_redirect;

`ifdef IPF_BYPASS_EN
  logic w_bypass;

  // Empty queue: present the returning word directly; skip the write if taken.
  assign w_bypass      = w_keep && w_empty;
  assign w_push        = w_keep && !(w_bypass && i_instr_ready) && !w_full;
  assign o_instr_valid = !w_empty || w_bypass;
  assign o_instr       = !w_empty ? w_head.instr : (w_bypass ? i_mem_rddata : '0);
  assign o_instr_pc    = !w_empty ? w_head.pc    : (w_bypass ? r_fill_pc    : '0);
`else
  assign w_push        = w_keep && !w_full;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_empty ? '0 : w_head.instr;
  assign o_instr_pc    = w_empty ? '0 : w_head.pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_fill_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
      if (i_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_fill_pc  <= w_redirect_pc;
        // Everything still in flight after this cycle is now stale.
        r_drop     <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + c_step;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_keep) r_fill_pc <= r_fill_pc + c_step;
      end
    end
  end

  ipf_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// Bench for instr_prefetch: directed table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_instr_prefetch;

  localparam int DEPTH = 4;
`ifdef IPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [3:0]  o_mem_byte_en;
  logic        i_mem_waitrequest;
  logic [31:0] i_mem_rddata;
  logic        i_mem_rdvalid;

  always #5 clk = ~clk;

  instr_prefetch #(
    .IW       (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .o_instr           (o_instr),
    .o_instr_pc        (o_instr_pc),
    .o_instr_valid     (o_instr_valid),
    .i_instr_ready     (i_instr_ready),
    .o_mem_addr        (o_mem_addr),
    .o_mem_rd          (o_mem_rd),
    .o_mem_byte_en     (o_mem_byte_en),
    .i_mem_waitrequest (i_mem_waitrequest),
    .i_mem_rddata      (i_mem_rddata),
    .i_mem_rdvalid     (i_mem_rdvalid)
  );

  typedef struct { logic [31:0] addr; bit stale; } inf_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    bit          ready;
    bit          exp_rd;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  inf_t        q_inf[$];
  ent_t        q_ent[$];
  mreq_t       q_mem[$];
  logic [31:0] m_fetch_pc;
  int          cyc, last_due, lat;
  int          n_tests, n_fail;
  logic        s_rd, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: in-flight fetches tagged stale on redirect; queue holds {word, fetch address}.
  task automatic model_step();
    bit   exp_rd, byp, exp_valid;
    ent_t head;
    inf_t f;
    exp_rd    = !i_redirect && ((q_ent.size() + q_inf.size()) < DEPTH);
    byp       = BYP && (q_ent.size() == 0) && i_mem_rdvalid && (q_inf.size() > 0)
                && !q_inf[0].stale && !i_redirect;
    exp_valid = (q_ent.size() > 0) || byp;
    chk("mem_rd", 32'(o_mem_rd), 32'(exp_rd));
    chk("mem_addr", o_mem_addr, m_fetch_pc);
    chk("byte_en", 32'(o_mem_byte_en), 32'hF);
    chk("instr_valid", 32'(o_instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (q_ent.size() > 0) head = q_ent[0];
      else head = '{instr: mem_word(q_inf[0].addr), pc: q_inf[0].addr};
      chk("instr_pc", o_instr_pc, head.pc);
      chk("instr", o_instr, head.instr);
    end
    if ((q_ent.size() > 0) && i_instr_ready && !i_redirect) void'(q_ent.pop_front());
    if (i_mem_rdvalid && (q_inf.size() > 0)) begin
      f = q_inf.pop_front();
      if (!f.stale && !i_redirect && !(byp && i_instr_ready))
        q_ent.push_back('{instr: mem_word(f.addr), pc: f.addr});
    end
    if (i_redirect) begin
      q_ent.delete();
      foreach (q_inf[i]) q_inf[i].stale = 1'b1;
      m_fetch_pc = i_redirect_pc & ~32'h3;
    end else if (exp_rd && !i_mem_waitrequest) begin
      q_inf.push_back('{addr: m_fetch_pc, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  // One clock: memory drives its response, outputs sampled at negedge, memory accepts.
  task automatic tick();
    if ((q_mem.size() > 0) && (q_mem[0].due <= cyc)) begin
      i_mem_rdvalid = 1'b1;
      i_mem_rddata  = mem_word(q_mem[0].addr);
      void'(q_mem.pop_front());
    end else begin
      i_mem_rdvalid = 1'b0;
      i_mem_rddata  = $urandom;
    end
    @(negedge clk);
    s_rd    = o_mem_rd;
    s_addr  = o_mem_addr;
    s_valid = o_instr_valid;
    s_pc    = o_instr_pc;
    s_instr = o_instr;
    model_step();
    if (o_mem_rd && !i_mem_waitrequest) begin
      int due;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_mem.push_back('{addr: o_mem_addr, due: due});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    i_redirect        = 1'b0;
    i_redirect_pc     = '0;
    i_instr_ready     = 1'b0;
    i_mem_waitrequest = 1'b0;
    i_mem_rdvalid     = 1'b0;
    i_mem_rddata      = '0;
    q_ent.delete();
    q_inf.delete();
    q_mem.delete();
    m_fetch_pc = 32'h0;
    last_due   = -1;
    #2;
    chk("reset_mem_rd", 32'(o_mem_rd), 32'h0);
    chk("reset_mem_addr", o_mem_addr, 32'h0);
    chk("reset_valid", 32'(o_instr_valid), 32'h0);
    chk("reset_instr", o_instr, 32'h0);
    chk("reset_instr_pc", o_instr_pc, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc += 2;
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (s_valid) begin
        seen = 1'b1;
        chk({name, "_pc"}, s_pc, exp_pc);
        chk({name, "_instr"}, s_instr, mem_word(exp_pc));
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'h1);
  endtask

  initial begin
    vec_t        vt[10];
    logic [31:0] wrap_exp[3];
    int          idx;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    lat     = 1;

    // Ready held low: queue fills to DEPTH, one pop frees a slot for 0x10.
    vt[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 32'h04, BYP,  32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    vt[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    vt[4] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[6] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
    vt[8] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h4};
    vt[9] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_instr_ready = vt[i].ready;
      tick();
      chk("tbl_rd", 32'(s_rd), 32'(vt[i].exp_rd));
      chk("tbl_addr", s_addr, vt[i].exp_addr);
      chk("tbl_valid", 32'(s_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk("tbl_pc", s_pc, vt[i].exp_pc);
        chk("tbl_instr", s_instr, mem_word(vt[i].exp_pc));
      end
    end

    // Waitrequest stall at 0x8.
    do_reset();
    i_instr_ready = 1'b1;
    tick();
    tick();
    i_mem_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wait_addr", s_addr, 32'h8);
      chk("wait_rd", 32'(s_rd), 32'h1);
    end
    i_mem_waitrequest = 1'b0;
    tick();
    chk("wait_release_addr", s_addr, 32'h8);
    tick();
    chk("wait_next_addr", s_addr, 32'hC);

    // Redirect to 0x100 with two fetches in flight.
    do_reset();
    lat = 3;
    tick();
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    chk("redir_rd", 32'(s_rd), 32'h0);
    i_redirect    = 1'b0;
    i_instr_ready = 1'b1;
    tick();
    chk("redir_addr", s_addr, 32'h100);
    chk("redir_empty", 32'(s_valid), 32'h0);
    wait_first_valid("redir", 32'h100);

    // Redirect to misaligned 0x203 together with a response and a pop.
    do_reset();
    lat = 1;
    i_instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h203;
    tick();
    chk("redir2_rd", 32'(s_rd), 32'h0);
    i_redirect = 1'b0;
    tick();
    chk("redir2_addr", s_addr, 32'h200);
    chk("redir2_empty", 32'(s_valid), 32'h0);
    wait_first_valid("redir2", 32'h200);

    // Address wrap at the top of the address space.
    do_reset();
    i_instr_ready = 1'b1;
    wrap_exp[0] = 32'hFFFF_FFFC;
    wrap_exp[1] = 32'h0;
    wrap_exp[2] = 32'h4;
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      i_redirect    = (k == 0);
      i_redirect_pc = 32'hFFFF_FFFC;
      tick();
      if (k == 1) chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      if (k == 2) chk("wrap_addr1", s_addr, 32'h0);
      if ((k > 0) && s_valid && (idx < 3)) begin
        chk("wrap_pc", s_pc, wrap_exp[idx]);
        idx++;
      end
    end
    chk("wrap_count", 32'(idx), 32'd3);

    // Randomized traffic against the model, with one reset mid-run.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      i_instr_ready     = ($urandom % 4) != 0;
      i_mem_waitrequest = ($urandom % 4) == 0;
      i_redirect        = ($urandom % 25) == 0;
      i_redirect_pc     = $urandom;
      lat               = 1 + ($urandom % 4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
